// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master engine.
// Holds the FSM state encoding, the AXI response codes and the default timeout.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESP         = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int TIMEOUT_DEFAULT = 256;

  // States in which the engine waits on the slave; only these are timed.
  function automatic logic is_wait_state(input state_t s);
    return (s == WR_ADDR_DATA) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi4_lite_timeout_ctr.sv
// Per-phase wait counter: cleared on every state entry, counts while enabled,
// flags expiry on the cycle it reaches TIMEOUT-1. TIMEOUT of 0 never expires.
module axi4_lite_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/axi4_lite_master_engine.sv
// Single-outstanding AXI4-Lite master: turns one command into one AW/W/B or AR/R
// transaction and reports a one-cycle response, with a per-phase timeout.
module axi4_lite_master_engine
  import axi4_lite_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000,
  parameter int         TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic                    bready_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rsp_resp_q;

  logic aw_fin;
  logic w_fin;
  logic leave;
  logic ctr_en;
  logic ctr_clr;
  logic expired;

  // A channel counts as finished once its handshake happened earlier or happens now.
  assign aw_fin = aw_done_q || (awvalid_q && awready);
  assign w_fin  = w_done_q  || (wvalid_q  && wready);

  always_comb begin
    leave = 1'b0;
    case (state_q)
      WR_ADDR_DATA: leave = aw_fin && w_fin;
      WR_RESP:      leave = bvalid;
      RD_ADDR:      leave = arready;
      RD_DATA:      leave = rvalid;
      default:      leave = 1'b0;
    endcase
  end

  // Holding the counter clear outside wait states and on every handshake exit
  // means it always starts from zero when a new phase is entered.
  assign ctr_en  = is_wait_state(state_q);
  assign ctr_clr = !ctr_en || leave;

  axi4_lite_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (ctr_clr),
    .enable  (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            if (cmd_write) begin
              state_q   <= WR_ADDR_DATA;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        WR_ADDR_DATA: begin
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && wready) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end else if (expired) begin
            state_q     <= RESP;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= RESP_SLVERR;
            rdata_q     <= '0;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            state_q     <= RESP;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= bresp;
            rdata_q     <= '0;
          end else if (expired) begin
            state_q     <= RESP;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= RESP_SLVERR;
            rdata_q     <= '0;
          end
        end

        RD_ADDR: begin
          if (arready) begin
            state_q   <= RD_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end else if (expired) begin
            state_q     <= RESP;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= RESP_SLVERR;
            rdata_q     <= '0;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            state_q     <= RESP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= rresp;
            rdata_q     <= rdata;
          end else if (expired) begin
            state_q     <= RESP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= RESP_SLVERR;
            rdata_q     <= '0;
          end
        end

        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign awaddr    = addr_q;
  assign awprot    = PROT;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = addr_q;
  assign arprot    = PROT;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = write_q ? '0 : rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master_engine.sv
// Bench for axi4_lite_master_engine: directed scenarios followed by random
// transactions against a memory-level reference model and a reactive slave.
module tb_axi4_lite_master_engine;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TO  = 16;
  localparam int LIM = 200;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0;
  logic          rready;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int cyc = 0;
  int aw_beats = 0;
  int w_beats = 0;
  int ar_beats = 0;
  int t_acc = 0;

  logic [AW-1:0] got_awaddr;
  logic [DW-1:0] got_wdata;
  logic [SW-1:0] got_wstrb;
  logic [AW-1:0] got_araddr;

  // ref_mem follows commands; slv_mem follows what actually crossed the bus.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  axi4_lite_master_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PROT       (3'b000),
    .TIMEOUT    (TO)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arprot    (arprot),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) aw_beats <= aw_beats + 1;
    if (wvalid && wready)   w_beats  <= w_beats + 1;
    if (arvalid && arready) ar_beats <= ar_beats + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("cmd_ready_wait", 64'(n < LIM), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge aclk);
    cmd_valid = 1'b0;
    t_acc = cyc;
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic aw_chan(input int dly, input logic [AW-1:0] a);
    int n = 0;
    while (awvalid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("aw_seen", 64'(n < LIM), 64'd1);
    for (int i = 0; i < dly; i++) begin
      check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, a}));
      @(negedge aclk);
    end
    check("aw_addr", 64'(awaddr), 64'(a));
    check("aw_prot", 64'(awprot), 64'd0);
    got_awaddr = awaddr;
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    check("aw_drop", 64'(awvalid), 64'd0);
  endtask

  task automatic w_chan(input int dly, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    while (wvalid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("w_seen", 64'(n < LIM), 64'd1);
    for (int i = 0; i < dly; i++) begin
      check("w_hold", 64'({wvalid, wstrb, wdata}), 64'({1'b1, s, d}));
      @(negedge aclk);
    end
    check("w_data", 64'({wstrb, wdata}), 64'({s, d}));
    got_wdata = wdata;
    got_wstrb = wstrb;
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    check("w_drop", 64'(wvalid), 64'd0);
  endtask

  task automatic b_chan(input int dly, input logic [1:0] resp);
    int n = 0;
    while (bready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("b_ready_seen", 64'(n < LIM), 64'd1);
    for (int i = 0; i < dly; i++) begin
      check("b_ready_hold", 64'(bready), 64'd1);
      @(negedge aclk);
    end
    slv_mem[got_awaddr] = merge(slv_mem.exists(got_awaddr) ? slv_mem[got_awaddr] : '0,
                                got_wdata, got_wstrb);
    bvalid = 1'b1;
    bresp = resp;
    @(negedge aclk);
    bvalid = 1'b0;
    bresp = 2'b00;
    check("b_ready_drop", 64'(bready), 64'd0);
  endtask

  task automatic ar_chan(input int dly, input logic [AW-1:0] a);
    int n = 0;
    while (arvalid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("ar_seen", 64'(n < LIM), 64'd1);
    for (int i = 0; i < dly; i++) begin
      check("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, a}));
      @(negedge aclk);
    end
    check("ar_addr", 64'({arprot, araddr}), 64'({3'b000, a}));
    got_araddr = araddr;
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    check("ar_drop", 64'(arvalid), 64'd0);
  endtask

  task automatic r_chan(input int dly, input logic [1:0] resp);
    int n = 0;
    while (rready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("r_ready_seen", 64'(n < LIM), 64'd1);
    for (int i = 0; i < dly; i++) begin
      check("r_ready_hold", 64'(rready), 64'd1);
      @(negedge aclk);
    end
    rvalid = 1'b1;
    rdata = slv_mem.exists(got_araddr) ? slv_mem[got_araddr] : '0;
    rresp = resp;
    @(negedge aclk);
    rvalid = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    check("r_ready_drop", 64'(rready), 64'd0);
  endtask

  task automatic get_rsp(input logic [DW-1:0] exp_d, input logic [1:0] exp_r, output int lat);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    check("rsp_seen", 64'(n < LIM), 64'd1);
    // The response is consumed at the next rising edge, hence the +1.
    lat = cyc + 1 - t_acc;
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
    check("rsp_resp", 64'(rsp_resp), 64'(exp_r));
    @(negedge aclk);
    check("rsp_pulse", 64'(rsp_valid), 64'd0);
  endtask

  task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input int d1, input int d2, input int d3,
                     input logic [1:0] resp);
    int aw0, w0, ar0, lat;
    logic [DW-1:0] exp_rd;
    aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
    if (wr) begin
      send_cmd(1'b1, a, d, s);
      fork
        aw_chan(d1, a);
        w_chan(d2, d, s);
      join
      b_chan(d3, resp);
      get_rsp('0, resp, lat);
      check("wr_latency", 64'(lat), 64'(3 + ((d1 > d2) ? d1 : d2) + d3));
      check("aw_beats", 64'(aw_beats - aw0), 64'd1);
      check("w_beats", 64'(w_beats - w0), 64'd1);
      ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : '0, d, s);
    end else begin
      exp_rd = ref_mem.exists(a) ? ref_mem[a] : '0;
      send_cmd(1'b0, a, '0, '0);
      ar_chan(d1, a);
      r_chan(d2, resp);
      get_rsp(exp_rd, resp, lat);
      check("rd_latency", 64'(lat), 64'(3 + d1 + d2));
      check("ar_beats", 64'(ar_beats - ar0), 64'd1);
    end
  endtask

  initial begin
    int n, ca, cw;
    logic          rwr;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [SW-1:0] rs;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_ctrl", 64'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
    check("rst_regs", 64'({awaddr, wdata}), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_release_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait write, then strobe-sensitive read back
    txn(1'b1, 32'h10, 32'hF0B4_A596, 4'b1011, 0, 0, 0, 2'b00);
    txn(1'b0, 32'h10, '0, '0, 0, 0, 0, 2'b00);
    check("strobe_merge", 64'(ref_mem[32'h10]), 64'h0000_0000_F000_A596);

    // W handshake four cycles ahead of AW
    txn(1'b1, 32'h10, 32'hF0B4_A596, 4'hF, 5, 1, 0, 2'b00);

    // Read with R delayed 5 cycles
    txn(1'b0, 32'h10, '0, '0, 0, 5, 0, 2'b00);

    // Slave error on write response
    txn(1'b1, 32'h14, 32'hCAFE_0001, 4'hF, 0, 0, 0, 2'b10);

    // Timeout with AW and W never accepted
    send_cmd(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    n = 0; ca = 0; cw = 0;
    while (rsp_valid !== 1'b1 && n < LIM) begin
      if (awvalid === 1'b1) ca++;
      if (wvalid === 1'b1) cw++;
      @(negedge aclk);
      n++;
    end
    check("to_rsp_seen", 64'(n < LIM), 64'd1);
    check("to_aw_cycles", 64'(ca), 64'(TO));
    check("to_w_cycles", 64'(cw), 64'(TO));
    check("to_resp", 64'(rsp_resp), 64'd2);
    check("to_rdata", 64'(rsp_rdata), 64'd0);
    check("to_valids_low", 64'({awvalid, wvalid, bready}), 64'd0);
    @(negedge aclk);
    check("to_rsp_pulse", 64'(rsp_valid), 64'd0);
    bvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("late_b_ignored", 64'({bready, rsp_valid, cmd_ready}), 64'b001);
    end
    bvalid = 1'b0;
    txn(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, 1, 0, 1, 2'b00);

    // Asynchronous reset while waiting in RD_DATA
    send_cmd(1'b0, 32'h10, '0, '0);
    ar_chan(0, 32'h10);
    check("in_rd_data", 64'(rready), 64'd1);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
    check("async_rst_data", 64'({araddr, rsp_rdata}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst2_release_ready", 64'(cmd_ready), 64'd1);
    txn(1'b0, 32'h10, '0, '0, 1, 2, 0, 2'b00);

    // Random traffic over a small address window
    for (int k = 0; k < 40; k++) begin
      rwr = 1'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 7)) << 2;
      rd  = DW'($urandom);
      rs  = SW'($urandom_range(0, 15));
      txn(rwr, ra, rd, rs, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
          2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master_engine.md
AXI4_LITE_MASTER_ENGINE -- requirements
Module: axi4_lite_master_engine
Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32 (32 or 64 only), data width; PROT, default 3'b000, value driven on awprot/arprot.
REQ-002 SHALL have parameter TIMEOUT, default 256, maximum wait cycles per channel phase; 0 disables the timeout.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports, one per line:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data, 0 for writes
rsp_resp  out  2  AXI response code, or 2'b10 on timeout
awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel
awready  in  1  write address accept
wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
wready  in  1  write data accept
bresp/bvalid  in  2/1  write response
bready  out  1  write response accept
araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel
arready  in  1  read address accept
rdata/rresp/rvalid  in  DATA_WIDTH/2/1  read data channel
rready  out  1  read data accept
Function
REQ-004 SHALL use states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RESP; exactly one transaction SHALL be outstanding at a time.
REQ-005 cmd_ready SHALL be high only in IDLE; on acceptance, cmd_addr, cmd_wdata, cmd_wstrb and cmd_write SHALL be registered; the next state SHALL be WR_ADDR_DATA or RD_ADDR.
REQ-006 WR_ADDR_DATA: awvalid and wvalid SHALL assert together on the first cycle; each SHALL drop independently on the cycle after its own ready is sampled high; the state SHALL exit to WR_RESP when both handshakes are done, in either order or in the same cycle.
REQ-007 A valid SHALL never drop before its ready is seen, and address/data SHALL stay stable while valid is high.
REQ-008 WR_RESP: bready SHALL be high; on bvalid, bresp SHALL be captured and the state SHALL go to RESP.
REQ-009 RD_ADDR: arvalid SHALL be high until arready, then the state SHALL go to RD_DATA. RD_DATA: rready SHALL be high; on rvalid, rdata and rresp SHALL be captured and the state SHALL go to RESP.
REQ-010 RESP SHALL pulse rsp_valid for exactly one cycle, then return to IDLE; minimum command-to-rsp latency SHALL be 3 cycles for a write and 3 cycles for a read when the slave has zero wait states.
REQ-011 Timeout: a counter SHALL clear on each state entry and increment per cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA; at TIMEOUT-1 the engine SHALL drop all valids/readies and go to RESP with rsp_resp=2'b10, rsp_rdata=0.
REQ-012 A late bvalid/rvalid after a timeout SHALL be ignored, because the matching ready is low.
Reset
REQ-013 Asserting aresetn low at any time, including mid-transaction, SHALL force IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid and cmd_ready SHALL be 0 during reset; registered address/data and the counter SHALL be 0; cmd_ready SHALL go to 1 on the first cycle after release.
Structure
REQ-014 The state encoding, response codes (OKAY 2'b00, SLVERR 2'b10) and the TIMEOUT default SHALL live in shared package axi4_lite_pkg.
REQ-015 One sub-module, axi4_lite_timeout_ctr (clear, enable, expired), SHALL implement the timeout; everything else SHALL be flat.
Verification
REQ-016 Write 0x10, 0xF0B4A596, strb 4'b1011, awready/wready/bvalid tied high -> single AW and W beat, rsp_valid 3 cycles after acceptance, rsp_resp=00.
REQ-017 Write with wready 4 cycles before awready -> wvalid drops first, awvalid holds stable, exactly one beat on each channel.
REQ-018 Read 0x10 with rvalid delayed 5 cycles, rdata 0xF0B4A596, rresp 00 -> rsp_rdata=0xF0B4A596, arvalid high for exactly 1 cycle.
REQ-019 TIMEOUT=16, awready never asserts -> awvalid and wvalid drop after 16 cycles, rsp_resp=10, then the next command is accepted.
REQ-020 aresetn pulled low while in RD_DATA -> all outputs 0 asynchronously, and a clean read completes after release.
REQ-021 bresp=SLVERR -> rsp_resp=10 on the response, with no stall.
